// File: rtl/chip8_fetch_sequencer.sv
// rtl/chip8_fetch_sequencer.sv - Chip-8 instruction fetch, PC/call-stack and flow-control sequencer
module chip8_fetch_sequencer #(
    parameter logic [11:0] PC_RESET    = 12'h200,
    parameter int          STACK_DEPTH = 16
) (
    input  logic        cpu_clk,
    input  logic        reset,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_readdata,
    output logic [15:0] instruction,
    output logic        instr_valid,
    output logic [3:0]  CONTROL,
    output logic [3:0]  reg_addr_x,
    output logic [3:0]  reg_addr_y,
    input  logic [7:0]  vx_readdata,
    input  logic [7:0]  vy_readdata,
    input  logic [15:0] keys,
    output logic [3:0]  key_value,
    input  logic        stall,
    output logic [11:0] pc,
    output logic [4:0]  sp,
    output logic        stack_error
);
    localparam int         SAW     = $clog2(STACK_DEPTH);
    localparam logic [4:0] SP_FULL = 5'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH_HI = 2'd0,
        S_FETCH_LO = 2'd1,
        S_LATCH    = 2'd2,
        S_EXEC     = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [11:0]    pc_q, pc_d;
    logic [11:0]    mem_addr_q, mem_addr_d;
    logic [4:0]     sp_q, sp_d;
    logic           err_q, err_d;
    logic           valid_q, valid_d;
    logic [3:0]     control_q, control_d;
    logic [7:0]     hi_q, hi_d;
    logic [15:0]    instr_q, instr_d;
    logic [11:0]    stack_q [STACK_DEPTH];
    logic           push_en;

    logic [3:0]     op, x;
    logic [7:0]     kk;
    logic [11:0]    nnn;
    logic           is_multi, is_keywait, skip, last_cycle;
    logic [11:0]    pc_plus2, pc_plus4;
    logic [SAW-1:0] push_idx, pop_idx;

    assign op         = instr_q[15:12];
    assign x          = instr_q[11:8];
    assign kk         = instr_q[7:0];
    assign nnn        = instr_q[11:0];
    assign is_multi   = (op == 4'hF) && ((kk == 8'h55) || (kk == 8'h65));
    assign is_keywait = (op == 4'hF) && (kk == 8'h0A);
    assign pc_plus2   = pc_q + 12'd2;
    assign pc_plus4   = pc_q + 12'd4;
    assign push_idx   = sp_q[SAW-1:0];
    assign pop_idx    = push_idx - SAW'(1);

    // Final exec cycle: not stalled, multicycle count done, and any key wait satisfied.
    assign last_cycle = !stall && !(is_multi && (control_q != x))
                        && !(is_keywait && (keys == 16'h0000));

    always_comb begin
        skip = 1'b0;
        case (op)
            4'h3:    skip = (vx_readdata == kk);
            4'h4:    skip = (vx_readdata != kk);
            4'h5:    skip = (instr_q[3:0] == 4'h0) && (vx_readdata == vy_readdata);
            4'h9:    skip = (instr_q[3:0] == 4'h0) && (vx_readdata != vy_readdata);
            4'hE:    skip = ((kk == 8'h9E) && keys[vx_readdata[3:0]])
                         || ((kk == 8'hA1) && !keys[vx_readdata[3:0]]);
            default: skip = 1'b0;
        endcase
    end

    always_comb begin
        key_value = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (keys[i]) key_value = i[3:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        err_d     = err_q;
        control_d = control_q;
        hi_d      = hi_q;
        instr_d   = instr_q;
        push_en   = 1'b0;
        case (state_q)
            S_FETCH_HI: state_d = S_FETCH_LO;
            S_FETCH_LO: begin
                hi_d    = mem_readdata;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                instr_d = {hi_q, mem_readdata};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!stall) begin
                    if (!last_cycle) begin
                        if (is_multi) control_d = control_q + 4'd1;
                    end else begin
                        control_d = 4'd0;
                        state_d   = S_FETCH_HI;
                        pc_d      = skip ? pc_plus4 : pc_plus2;
                        case (op)
                            4'h1: pc_d = nnn;
                            4'h2: begin
                                pc_d = nnn;
                                if (sp_q == SP_FULL) begin
                                    err_d = 1'b1;
                                end else begin
                                    push_en = 1'b1;
                                    sp_d    = sp_q + 5'd1;
                                end
                            end
                            4'h0: begin
                                if (instr_q == 16'h00EE) begin
                                    if (sp_q == 5'd0) begin
                                        err_d = 1'b1;
                                    end else begin
                                        pc_d = stack_q[pop_idx];
                                        sp_d = sp_q - 5'd1;
                                    end
                                end
                            end
                            4'hB:    pc_d = nnn + {4'h0, vy_readdata};
                            default: pc_d = skip ? pc_plus4 : pc_plus2;
                        endcase
                    end
                end
            end
            default: state_d = S_FETCH_HI;
        endcase
        valid_d    = (state_d == S_EXEC);
        mem_addr_d = (state_d == S_FETCH_LO) ? (pc_d + 12'd1) : pc_d;
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q    <= S_FETCH_HI;
            pc_q       <= PC_RESET;
            mem_addr_q <= PC_RESET;
            sp_q       <= 5'd0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            control_q  <= 4'd0;
            hi_q       <= 8'h00;
            instr_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            control_q  <= control_d;
            hi_q       <= hi_d;
            instr_q    <= instr_d;
            if (push_en) stack_q[push_idx] <= pc_plus2;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign instr_valid = valid_q;
    assign instruction = valid_q ? instr_q : 16'h0000;
    assign CONTROL     = control_q;
    assign reg_addr_x  = x;
    assign reg_addr_y  = (op == 4'hB) ? 4'h0 : instr_q[7:4];
    assign pc          = pc_q;
    assign sp          = sp_q;
    assign stack_error = err_q;

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// tb/tb_chip8_fetch_sequencer.sv - randomized bench with instruction-level reference model
module tb_chip8_fetch_sequencer;
    logic        cpu_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [11:0] mem_addr;
    logic [7:0]  mem_readdata;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [3:0]  CONTROL;
    logic [3:0]  reg_addr_x, reg_addr_y;
    logic [7:0]  vx_readdata, vy_readdata;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  key_value;
    logic        stall = 1'b0;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        stack_error;

    logic [7:0]  mem [4096];
    logic [7:0]  vregs [16];
    logic [11:0] pc_m;
    logic [11:0] stack_m [$];
    logic        err_m;
    int          tests_run = 0;
    int          tests_failed = 0;

    chip8_fetch_sequencer dut (
        .cpu_clk(cpu_clk), .reset(reset), .mem_addr(mem_addr), .mem_readdata(mem_readdata),
        .instruction(instruction), .instr_valid(instr_valid), .CONTROL(CONTROL),
        .reg_addr_x(reg_addr_x), .reg_addr_y(reg_addr_y), .vx_readdata(vx_readdata),
        .vy_readdata(vy_readdata), .keys(keys), .key_value(key_value), .stall(stall),
        .pc(pc), .sp(sp), .stack_error(stack_error)
    );

    always #5 cpu_clk = ~cpu_clk;
    always @(posedge cpu_clk) mem_readdata <= mem[mem_addr];
    assign vx_readdata = vregs[reg_addr_x];
    assign vy_readdata = vregs[reg_addr_y];

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        step();
        step();
        reset = 1'b0;
        pc_m = 12'h200;
        stack_m.delete();
        err_m = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!instr_valid && waited < 8) begin
            step();
            waited++;
        end
    endtask

    // Instruction-level reference: next PC and stack effect of one retired instruction.
    task automatic model_exec(input logic [15:0] op);
        logic [7:0] vx, vy;
        logic       skip;
        vx   = vregs[op[11:8]];
        vy   = vregs[op[7:4]];
        skip = 1'b0;
        case (op[15:12])
            4'h3: skip = (vx == op[7:0]);
            4'h4: skip = (vx != op[7:0]);
            4'h5: skip = (op[3:0] == 4'h0) && (vx == vy);
            4'h9: skip = (op[3:0] == 4'h0) && (vx != vy);
            4'hE: skip = (op[7:0] == 8'h9E && keys[vx[3:0]] == 1'b1)
                      || (op[7:0] == 8'hA1 && keys[vx[3:0]] == 1'b0);
            default: skip = 1'b0;
        endcase
        if (op[15:12] == 4'h1) begin
            pc_m = op[11:0];
        end else if (op[15:12] == 4'h2) begin
            if (stack_m.size() == 16) err_m = 1'b1;
            else stack_m.push_back(pc_m + 12'd2);
            pc_m = op[11:0];
        end else if (op == 16'h00EE) begin
            if (stack_m.size() == 0) begin
                err_m = 1'b1;
                pc_m  = pc_m + 12'd2;
            end else begin
                pc_m = stack_m.pop_back();
            end
        end else if (op[15:12] == 4'hB) begin
            pc_m = op[11:0] + {4'h0, vregs[0]};
        end else begin
            pc_m = pc_m + (skip ? 12'd4 : 12'd2);
        end
    endtask

    task automatic run_instr(input logic [15:0] op, input logic [31:0] stall_mask);
        int         waited, i, ctl;
        bit         fin, multi;
        logic [11:0] a;
        a = pc_m;
        mem[a] = op[15:8];
        a = pc_m + 12'd1;
        mem[a] = op[7:0];
        wait_valid(waited);
        tests_run++;
        if (waited !== 3) begin
            tests_failed++;
            $display("FAIL fetch_latency op=%h got %0d cycles want 3", op, waited);
        end
        tests_run++;
        if (instruction !== op) begin
            tests_failed++;
            $display("FAIL instruction got %h want %h", instruction, op);
        end
        multi = (op[15:12] == 4'hF) && (op[7:0] == 8'h55 || op[7:0] == 8'h65);
        ctl = 0;
        i = 0;
        fin = 0;
        while (!fin && i < 48 && instr_valid) begin
            tests_run++;
            if (CONTROL !== 4'(ctl) || pc !== pc_m) begin
                tests_failed++;
                $display("FAIL exec_cycle op=%h i=%0d CONTROL=%0d pc=%h want CONTROL=%0d pc=%h",
                         op, i, CONTROL, pc, ctl, pc_m);
            end
            stall = (i < 32) ? stall_mask[i] : 1'b0;
            fin = !stall && (!multi || ctl == int'(op[11:8]));
            if (!stall && !fin) ctl++;
            step();
            stall = 1'b0;
            i++;
        end
        tests_run++;
        if (!fin) begin
            tests_failed++;
            $display("FAIL exec_exit op=%h left after %0d cycles, exit was expected", op, i);
        end
        model_exec(op);
        tests_run++;
        if (instr_valid !== 1'b0 || instruction !== 16'h0 || pc !== pc_m || mem_addr !== pc_m
            || sp !== 5'(stack_m.size()) || stack_error !== err_m || CONTROL !== 4'h0) begin
            tests_failed++;
            $display("FAIL retire op=%h valid=%b instr=%h pc=%h addr=%h sp=%0d err=%b ctl=%0d want pc=%h sp=%0d err=%b",
                     op, instr_valid, instruction, pc, mem_addr, sp, stack_error, CONTROL,
                     pc_m, stack_m.size(), err_m);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (pc !== 12'h200 || sp !== 5'd0 || stack_error !== 1'b0 || CONTROL !== 4'h0
            || instr_valid !== 1'b0 || instruction !== 16'h0 || mem_addr !== 12'h200) begin
            tests_failed++;
            $display("FAIL reset pc=%h sp=%0d err=%b ctl=%0d valid=%b instr=%h addr=%h",
                     pc, sp, stack_error, CONTROL, instr_valid, instruction, mem_addr);
        end
    endtask

    task automatic test_fetch_latency();
        logic [11:0] exp_addr [5];
        logic        exp_valid [5];
        do_reset();
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        exp_addr  = '{12'h200, 12'h201, 12'h201, 12'h201, 12'h234};
        exp_valid = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (instr_valid !== exp_valid[c] || (c < 2 && mem_addr !== exp_addr[c])
                || (c == 4 && mem_addr !== exp_addr[c])
                || (c == 3 && instruction !== 16'h1234)) begin
                tests_failed++;
                $display("FAIL latency cycle=%0d valid=%b addr=%h instr=%h want valid=%b addr=%h",
                         c, instr_valid, mem_addr, instruction, exp_valid[c], exp_addr[c]);
            end
            step();
        end
        do_reset();
    endtask

    task automatic test_call_return();
        do_reset();
        run_instr(16'h2300, 32'h0);
        run_instr(16'h00EE, 32'h0);
        tests_run++;
        if (pc !== 12'h202 || sp !== 5'd0) begin
            tests_failed++;
            $display("FAIL call_return pc=%h sp=%0d want 202 0", pc, sp);
        end
    endtask

    task automatic test_stack_errors();
        do_reset();
        for (int k = 0; k < 17; k++) run_instr({4'h2, pc_m + 12'h010}, 32'h0);
        tests_run++;
        if (sp !== 5'd16 || stack_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow sp=%0d err=%b want 16 1", sp, stack_error);
        end
        run_instr(16'h00EE, 32'h0);
        do_reset();
        tests_run++;
        if (stack_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_clear err=%b want 0", stack_error);
        end
        run_instr(16'h00EE, 32'h0);
        run_instr(16'h6000, 32'h0);
    endtask

    task automatic test_skips();
        do_reset();
        vregs[3] = 8'h42;
        run_instr(16'h3342, 32'h0);
        vregs[3] = 8'h41;
        run_instr(16'h3342, 32'h0);
        vregs[7] = 8'h05;
        keys = 16'h0020;
        run_instr(16'hE79E, 32'h0);
        run_instr(16'hE7A1, 32'h0);
        keys = 16'h0000;
        run_instr(16'h1FFE, 32'h0);
        run_instr(16'h6000, 32'h0);
    endtask

    task automatic test_multicycle();
        do_reset();
        run_instr(16'hF355, 32'h2);
        run_instr(16'hF065, 32'h0);
        run_instr(16'hFF65, 32'h5);
    endtask

    task automatic test_key_wait();
        int          waited;
        logic [11:0] a;
        do_reset();
        run_instr(16'h2400, 32'h0);
        keys = 16'h0000;
        a = pc_m;
        mem[a] = 8'hF0;
        a = pc_m + 12'd1;
        mem[a] = 8'h0A;
        wait_valid(waited);
        for (int c = 0; c < 10; c++) begin
            step();
            tests_run++;
            if (instr_valid !== 1'b1 || key_value !== 4'h0 || pc !== pc_m) begin
                tests_failed++;
                $display("FAIL key_hold c=%0d valid=%b key=%0d pc=%h", c, instr_valid, key_value, pc);
            end
        end
        keys = 16'h0100;
        #1;
        tests_run++;
        if (key_value !== 4'h8) begin
            tests_failed++;
            $display("FAIL key_value got %0d want 8", key_value);
        end
        step();
        pc_m = pc_m + 12'd2;
        tests_run++;
        if (instr_valid !== 1'b0 || pc !== pc_m) begin
            tests_failed++;
            $display("FAIL key_exit valid=%b pc=%h want 0 %h", instr_valid, pc, pc_m);
        end
        keys = 16'h0000;
        a = pc_m;
        mem[a] = 8'hF0;
        a = pc_m + 12'd1;
        mem[a] = 8'h0A;
        wait_valid(waited);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (pc !== 12'h200 || sp !== 5'd0 || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_wait pc=%h sp=%0d valid=%b want 200 0 0", pc, sp, instr_valid);
        end
        pc_m = 12'h200;
        stack_m.delete();
        err_m = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] op;
        logic [3:0]  xr, yr;
        logic [3:0]  unk [6];
        unk = '{4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hD};
        do_reset();
        for (int n = 0; n < 80; n++) begin
            for (int r = 0; r < 16; r++) vregs[r] = 8'($urandom);
            keys = 16'($urandom);
            xr = 4'($urandom);
            yr = 4'($urandom);
            op = 16'($urandom);
            case ($urandom_range(0, 11))
                0:  op = {4'h1, op[11:0]};
                1:  op = {4'h2, op[11:0]};
                2:  op = 16'h00EE;
                3:  op = {4'hB, op[11:0]};
                4:  op = {4'h3, xr, ($urandom_range(0, 1) == 1) ? vregs[xr] : op[7:0]};
                5:  op = {4'h4, xr, ($urandom_range(0, 1) == 1) ? vregs[xr] : op[7:0]};
                6:  begin
                        if ($urandom_range(0, 1) == 1) vregs[yr] = vregs[xr];
                        op = {4'h5, xr, yr, 4'h0};
                    end
                7:  op = {4'h9, xr, yr, 4'h0};
                8:  op = {4'hE, xr, 8'h9E};
                9:  op = {4'hE, xr, 8'hA1};
                10: op = {4'hF, xr, ($urandom_range(0, 1) == 1) ? 8'h55 : 8'h65};
                default: op = {unk[$urandom_range(0, 5)], op[11:0]};
            endcase
            run_instr(op, $urandom & $urandom & $urandom & 32'h0000_FFFF);
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        for (int r = 0; r < 16; r++) vregs[r] = 8'h00;
        test_reset();
        test_fetch_latency();
        test_call_return();
        test_stack_errors();
        test_skips();
        test_multicycle();
        test_key_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
